// File: rtl/msk_pkg.sv
// Shared definitions for the MSK masking encoder: default share count,
// share-bus indexing and randomness width helpers, FIFO occupancy states.
package msk_pkg;

  localparam int DEFAULTSHARES = 2;
  localparam int DEFAULTWIDTH  = 8;

  // Occupancy of the two-entry output buffer
  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_TWO   = 2'd2
  } fifo_level_e;

  // Position of bit b of share j on the MSK bus
  function automatic int idx(input int b, input int j, input int d);
    return b * d + j;
  endfunction

  // Fresh random bits needed per plaintext word
  function automatic int rnd_width(input int d, input int w);
    return (d - 1) * w;
  endfunction

endpackage

// File: rtl/msk_sharing_fifo.sv
// Two-entry ordered output buffer for finished sharings. The head entry drives
// the output directly from a register, and every popped entry is cleared so no
// share value lingers in the buffer after it has left.
module msk_sharing_fifo
  import msk_pkg::*;
#(
  parameter int d = DEFAULTSHARES,
  parameter int W = DEFAULTWIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [d*W-1:0] push_data,
  output logic           can_push,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [d*W-1:0] out_shares
);

  fifo_level_e    level;
  fifo_level_e    level_next;
  logic [d*W-1:0] head;
  logic [d*W-1:0] tail;
  logic           pop;
  logic           push_ok;

  assign out_valid  = rst_n && (level != LVL_EMPTY);
  assign pop        = out_valid && out_ready;
  assign can_push   = rst_n && ((level != LVL_TWO) || pop);
  assign push_ok    = push && can_push;
  assign out_shares = head;

  // Next occupancy from the push/pop pair; push and pop together keep the level
  always_comb begin
    level_next = level;
    case (level)
      LVL_EMPTY: if (push_ok) level_next = LVL_ONE;
      LVL_ONE: begin
        if (push_ok && !pop)      level_next = LVL_TWO;
        else if (!push_ok && pop) level_next = LVL_EMPTY;
      end
      LVL_TWO:   if (pop && !push_ok) level_next = LVL_ONE;
      default:   level_next = LVL_EMPTY;
    endcase
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (!rst_n) level <= LVL_EMPTY;
    else        level <= level_next;
  end

  // Entry storage: head shifts forward on pop, vacated slots are cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          if (level == LVL_EMPTY) head <= push_data;
          else                    tail <= push_data;
        end
        2'b01: begin
          head <= tail;
          tail <= '0;
        end
        2'b11: begin
          if (level == LVL_ONE) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/msk_encoder_stream.sv
// Streaming Boolean masking encoder: each plaintext word is held in a single
// staging register until a fresh randomness word arrives, then split into d
// shares and registered into the output buffer in the same cycle.
module msk_encoder_stream
  import msk_pkg::*;
#(
  parameter int d = DEFAULTSHARES,
  parameter int W = DEFAULTWIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W-1:0]               in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [rnd_width(d, W)-1:0] rnd,
  input  logic                       rnd_valid,
  output logic                       rnd_ready,
  output logic [d*W-1:0]             out_shares,
  output logic                       out_valid,
  input  logic                       out_ready
);

  logic [W-1:0]   s1_data;
  logic           s1_full;
  logic [W-1:0]   share0;
  logic [d*W-1:0] share_word;
  logic           can_push;
  logic           rnd_fire;
  logic           in_fire;

  // Randomness is only taken when a word is waiting and the buffer can accept it
  assign rnd_ready = rst_n && s1_full && can_push;
  assign rnd_fire  = rnd_valid && rnd_ready;
  assign in_ready  = rst_n && (!s1_full || rnd_fire);
  assign in_fire   = in_valid && in_ready;

  // Split the staged word: shares 1..d-1 are the random slices, share 0 absorbs them all
  always_comb begin
    share0     = s1_data;
    share_word = '0;
    for (int k = 1; k < d; k++) begin
      share0 = share0 ^ rnd[(k-1)*W +: W];
    end
    for (int b = 0; b < W; b++) begin
      share_word[idx(b, 0, d)] = share0[b];
      for (int k = 1; k < d; k++) begin
        share_word[idx(b, k, d)] = rnd[(k-1)*W + b];
      end
    end
  end

  // Staging register: reload on accept, clear to zero once the word has been shared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_full <= 1'b0;
    end else if (in_fire) begin
      s1_data <= in_data;
      s1_full <= 1'b1;
    end else if (rnd_fire) begin
      s1_data <= '0;
      s1_full <= 1'b0;
    end
  end

  msk_sharing_fifo #(
    .d(d),
    .W(W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (rnd_fire),
    .push_data  (share_word),
    .can_push   (can_push),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares)
  );

endmodule

// File: tb/tb_msk_encoder_stream.sv
// Bench for msk_encoder_stream: a d=2 instance driven from a vector table and
// a d=3 instance driven with random traffic against a queue-based share model.
module tb_msk_encoder_stream;

  localparam int W  = 8;
  localparam int D3 = 3;

  logic clk;
  logic rst_n;

  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [2*W-1:0]    rnd;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [D3*W-1:0]   out_shares;
  logic              out_valid;
  logic              out_ready;

  logic [W-1:0]      in_data_b;
  logic              in_valid_b;
  logic              in_ready_b;
  logic [W-1:0]      rnd_b;
  logic              rnd_valid_b;
  logic              rnd_ready_b;
  logic [2*W-1:0]    out_shares_b;
  logic              out_valid_b;
  logic              out_ready_b;

  int checks;
  int failures;
  int out_cnt;
  int rnd_fire_cnt;
  int words_left;
  bit in_fired;
  bit rnd_fired;

  logic [W-1:0]   word_q[$];
  logic [2*W-1:0] rnd_q[$];

  typedef struct {
    logic [7:0] in_word;
    logic [7:0] rnd_word;
    logic [7:0] exp_s0;
    logic [7:0] exp_s1;
  } vec_t;

  vec_t vecs[6];

  msk_encoder_stream #(.d(D3), .W(W)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .out_shares(out_shares), .out_valid(out_valid), .out_ready(out_ready)
  );

  msk_encoder_stream #(.d(2), .W(W)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .rnd(rnd_b), .rnd_valid(rnd_valid_b), .rnd_ready(rnd_ready_b),
    .out_shares(out_shares_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Extract share j of a d-share bus (bit b of share j sits at b*d+j)
  function automatic logic [7:0] get_share(input logic [23:0] bus, input int j, input int d);
    logic [7:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) s[b] = bus[b*d + j];
    return s;
  endfunction

  // Expected d=3 bus from a plaintext word and its randomness word
  function automatic logic [23:0] build_bus(input logic [7:0] word, input logic [15:0] r);
    logic [7:0]  sh[3];
    logic [23:0] bus;
    sh[1] = r[7:0];
    sh[2] = r[15:8];
    sh[0] = word ^ sh[1] ^ sh[2];
    bus = '0;
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < 8; b++) bus[b*3 + j] = sh[j][b];
    return bus;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // One cycle of d=3 traffic: hold data while valid and not accepted, else draw new
  task automatic applyStimulus(input bit in_en, input int rnd_pct, input int out_pct);
    @(posedge clk);
    #1;
    if (!(in_valid && !in_fired)) begin
      if (in_en && words_left > 0) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        words_left--;
      end else begin
        in_valid = 1'b0;
      end
    end
    if (!(rnd_valid && !rnd_fired)) begin
      rnd_valid = ($urandom_range(99) < rnd_pct);
      if (rnd_valid) rnd = 16'($urandom);
    end
    out_ready = ($urandom_range(99) < out_pct);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
    words_left = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model for the d=3 instance: words and randomness in arrival order
  always @(negedge clk) begin
    if (!rst_n) begin
      word_q.delete();
      rnd_q.delete();
      in_fired  = 1'b0;
      rnd_fired = 1'b0;
    end else begin
      in_fired  = in_valid && in_ready;
      rnd_fired = rnd_valid && rnd_ready;
      if (out_valid && out_ready) begin
        if (rnd_q.size() == 0 || word_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output actual=%0h expected=none", out_shares);
        end else begin
          logic [7:0]  w;
          logic [15:0] r;
          w = word_q.pop_front();
          r = rnd_q.pop_front();
          checkOutput("share_bus", 32'(out_shares), 32'(build_bus(w, r)));
          checkOutput("recombine", 32'(get_share(out_shares, 0, 3) ^ get_share(out_shares, 1, 3) ^
                                      get_share(out_shares, 2, 3)), 32'(w));
        end
        out_cnt++;
      end else if (!out_valid) begin
        checkOutput("idle_zero", 32'(out_shares), 32'h0);
      end
      if (rnd_fired) begin
        checkOutput("rnd_pending", 32'(word_q.size() > rnd_q.size()), 32'h1);
        rnd_q.push_back(rnd);
        rnd_fire_cnt++;
      end
      if (in_fired) word_q.push_back(in_data);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int so, sr, lat, first, gaps;
    bit rfb;
    checks = 0; failures = 0; out_cnt = 0; rnd_fire_cnt = 0; words_left = 0;
    in_fired = 0; rnd_fired = 0;
    in_data = '0; rnd = '0; in_data_b = '0; rnd_b = '0;
    in_valid_b = 0; rnd_valid_b = 0; out_ready_b = 0;

    vecs[0] = '{8'hA5, 8'h3C, 8'h99, 8'h3C};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{8'h12, 8'h34, 8'h26, 8'h34};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[5] = '{8'h80, 8'h01, 8'h81, 8'h01};

    // Reset held two cycles with every valid and ready asserted
    rst_n = 0; in_valid = 1; rnd_valid = 1; out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_rnd_ready", 32'(rnd_ready), 0);
      checkOutput("rst_in_ready", 32'(in_ready), 0);
    end
    checkOutput("rst_out_shares", 32'(out_shares), 0);
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0; rnd_valid = 0; out_ready = 0;
    @(negedge clk);
    checkOutput("rst_release_in_ready", 32'(in_ready), 1);

    // d=2 vector table: one word per entry, latency and share values
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid_b = 1; in_data_b = vecs[i].in_word;
      rnd_valid_b = 1; rnd_b = vecs[i].rnd_word; out_ready_b = 1;
      @(negedge clk);
      checkOutput("vec_in_ready", 32'(in_ready_b), 1);
      lat = -1; rfb = 0;
      for (int c = 1; c <= 6; c++) begin
        @(posedge clk); #1;
        in_valid_b = 0;
        if (rfb) rnd_valid_b = 0;
        @(negedge clk);
        rfb = rnd_valid_b && rnd_ready_b;
        if (out_valid_b) begin
          lat = c;
          break;
        end
      end
      checkOutput("vec_latency", 32'(lat), 2);
      checkOutput("vec_share0", 32'(get_share({8'h0, out_shares_b}, 0, 2)), 32'(vecs[i].exp_s0));
      checkOutput("vec_share1", 32'(get_share({8'h0, out_shares_b}, 1, 2)), 32'(vecs[i].exp_s1));
      checkOutput("vec_recombine", 32'(get_share({8'h0, out_shares_b}, 0, 2) ^
                                       get_share({8'h0, out_shares_b}, 1, 2)), 32'(vecs[i].in_word));
    end
    @(posedge clk); #1;
    rnd_valid_b = 0; out_ready_b = 0;

    // d=3 random stream: 16 words, randomness half the time, random backpressure
    resetDut();
    so = out_cnt; sr = rnd_fire_cnt; words_left = 16;
    for (int c = 0; c < 400 && (out_cnt - so) < 16; c++) begin
      applyStimulus(1, 50, 70);
      @(negedge clk); #1;
    end
    checkOutput("stream_outputs", 32'(out_cnt - so), 16);
    checkOutput("stream_rnd_fires", 32'(rnd_fire_cnt - sr), 16);

    // Stall: output blocked for six cycles while feeding three words
    resetDut();
    so = out_cnt; sr = rnd_fire_cnt; words_left = 3;
    for (int c = 0; c < 6; c++) applyStimulus(1, 100, 0);
    @(negedge clk);
    checkOutput("stall_out_valid", 32'(out_valid), 1);
    checkOutput("stall_in_ready", 32'(in_ready), 0);
    checkOutput("stall_rnd_ready", 32'(rnd_ready), 0);
    checkOutput("stall_rnd_fires", 32'(rnd_fire_cnt - sr), 2);
    checkOutput("stall_outputs", 32'(out_cnt - so), 0);
    for (int c = 0; c < 20 && (out_cnt - so) < 3; c++) begin
      applyStimulus(0, 100, 100);
      @(negedge clk); #1;
    end
    checkOutput("drain_outputs", 32'(out_cnt - so), 3);
    checkOutput("drain_rnd_fires", 32'(rnd_fire_cnt - sr), 3);

    // Full throughput: everything held high for 32 words
    resetDut();
    so = out_cnt; words_left = 32; first = -1; gaps = 0;
    for (int c = 1; c <= 100 && (out_cnt - so) < 32; c++) begin
      applyStimulus(1, 100, 100);
      @(negedge clk); #1;
      if (out_valid || (out_cnt - so) == 32) begin
        if (first < 0) first = c;
      end else if (first >= 0) begin
        gaps++;
      end
    end
    checkOutput("tput_first_valid", 32'(first), 3);
    checkOutput("tput_gaps", 32'(gaps), 0);
    checkOutput("tput_outputs", 32'(out_cnt - so), 32);

    // Reset with buffer and staging register full: nothing stale may appear
    resetDut();
    words_left = 4;
    for (int c = 0; c < 6; c++) applyStimulus(1, 100, 0);
    @(negedge clk);
    checkOutput("prerst_out_valid", 32'(out_valid), 1);
    checkOutput("prerst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 0; out_ready = 1;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready), 0);
    checkOutput("midrst_rnd_ready", 32'(rnd_ready), 0);
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0; rnd_valid = 0; words_left = 0;
    @(negedge clk);
    checkOutput("postrst_out_valid", 32'(out_valid), 0);
    checkOutput("postrst_out_shares", 32'(out_shares), 0);
    checkOutput("postrst_in_ready", 32'(in_ready), 1);
    checkOutput("postrst_rnd_ready", 32'(rnd_ready), 0);
    so = out_cnt;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 100, 100);
      @(negedge clk); #1;
    end
    checkOutput("postrst_no_output", 32'(out_cnt - so), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
